// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- sequential signed integer divider (DIV instruction).
//
// Restoring divider, one quotient bit per clock. The quotient goes to lo
// and the remainder to hi. The control unit pulses start and then stalls
// while busy is high, until done.
//
// Optional build macro: DIV_UNIT_UNSIGNED_EN
//   When it is defined, the block gains a sign_en input that is sampled
//   with start. sign_en=0 selects DIVU semantics (raw operands, no sign
//   fix-up). When it is undefined, the divider is always signed.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,   // operand/result width
    parameter int CNT_W = 6     // iteration counter width, 2**CNT_W > WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNIT_UNSIGNED_EN
    input  logic             sign_en,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // datapath registers
    logic [WIDTH-1:0] r_divisor;   // |B| (or raw B in unsigned mode)
    logic [WIDTH-1:0] r_quot;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_rem;       // partial remainder, always < r_divisor
    logic [CNT_W-1:0] r_cnt;       // remaining restoring steps
    logic             r_sign_q;    // negate quotient in FIX
    logic             r_sign_r;    // negate remainder in FIX
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    // control strobes from the FSM
    logic w_load;       // accept operands and enter RUN
    logic w_step;       // perform one restoring step
    logic w_fix;        // write signed results to hi/lo
    logic w_zero_hit;   // divide-by-zero request seen in IDLE

    // operand conditioning
    logic             w_signed;
    logic             w_b_zero;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    // restoring step
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [CNT_W-1:0] w_cnt_dec;

    // final sign fix-up
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

`ifdef DIV_UNIT_UNSIGNED_EN
    assign w_signed = sign_en;
`else
    assign w_signed = 1'b1;
`endif

    assign w_b_zero = (B == '0);
    assign w_a_neg  = w_signed & A[WIDTH-1];
    assign w_b_neg  = w_signed & B[WIDTH-1];

    // The most negative value negates to itself. Read as unsigned, that is
    // exactly its magnitude 2**(WIDTH-1), so no special case is needed.
    assign w_a_mag  = w_a_neg ? (-A) : A;
    assign w_b_mag  = w_b_neg ? (-B) : B;

    // The shifted remainder needs WIDTH+1 bits. Because rem < divisor
    // before the shift, the shifted value is < 2*divisor. The WIDTH+1-bit
    // difference therefore has its top bit set exactly when the shifted
    // value is below the divisor, so that bit acts as the compare result.
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_rem_diff[WIDTH];
    assign w_rem_next  = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};
    assign w_cnt_dec   = r_cnt - CNT_W'(1);

    // The quotient truncates toward zero. The remainder takes the sign of
    // the dividend.
    assign w_lo_fix = r_sign_q ? (-r_quot) : r_quot;
    assign w_hi_fix = r_sign_r ? (-r_rem)  : r_rem;

    // State register; reset returns to IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control-strobe decode
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        w_zero_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_b_zero) begin
                        w_zero_hit = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_cnt_dec == '0) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_fix        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Iteration datapath: load operands, then shift/subtract once per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
        end else if (w_load) begin
            r_divisor <= w_b_mag;
            r_quot    <= w_a_mag;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(WIDTH);
            r_sign_q  <= w_a_neg ^ w_b_neg;
            r_sign_r  <= w_a_neg;
        end else if (w_step) begin
            r_quot    <= w_quot_next;
            r_rem     <= w_rem_next;
            r_cnt     <= w_cnt_dec;
        end
    end

    // Result registers hold until the next completed division
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
        end
    end

    // Completion and divide-by-zero pulses, each one cycle wide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= w_fix | w_zero_hit;
            r_div_zero <= w_zero_hit;
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed integer divider for the multicycle datapath; implements the DIV instruction.
- Consumes operand register values A (dividend) and B (divisor), the same values routed to the ALU operand muxes.
- Writes quotient to LO and remainder to HI.
- Control unit pulses start, then stalls on busy until done.

Parameters:
- WIDTH, 32, operand/result width in bits. The design is verified only at 32.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  dividend, two's complement
- B  input  WIDTH  divisor, two's complement
- hi  output  WIDTH  remainder register
- lo  output  WIDTH  quotient register
- busy  output  1  high while in RUN or FIX
- done  output  1  one-cycle pulse when hi/lo are updated or div_zero is raised
- div_zero  output  1  one-cycle pulse, coincident with done, when B==0

Behaviour:
- Reset (asynchronous, active-high, immediate): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, all internal registers=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - On start=1 and B!=0: latch |A|, |B|, sign_q=A[msb]^B[msb], sign_r=A[msb]; clear partial remainder; counter=WIDTH; go to RUN.
  - On start=1 and B==0: stay IDLE; pulse done=1 and div_zero=1 next cycle; hi/lo unchanged.
- RUN: one restoring step per cycle.
  - rem = {rem[WIDTH-2:0], quot[msb]}; quot shifted left.
  - If rem >= |B|: rem -= |B| and the quotient LSB is 1.
  - Counter decrements; on reaching 0, go to FIX.
  - Internal remainder path is WIDTH+1 bits so the compare cannot overflow.
- FIX:
  - lo = sign_q ? -quot : quot.
  - hi = sign_r ? -rem : rem.
  - Pulse done=1; go to IDLE.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Latency: start sampled at edge 0; done high during the cycle after edge WIDTH+1 (33 cycles at WIDTH=32).
- busy rises on the edge after start and falls with the FIX edge; busy and done are never high together.
- start while busy is ignored; operands are not re-sampled.
- Overflow 0x80000000 / 0xFFFFFFFF: |A|=2^31 is held unsigned, so lo=0x80000000 (wraps) and hi=0. No flag is raised.
- Zero dividend: lo=0, hi=0, full latency.
- hi/lo hold their values until the next successful FIX. A/B may change freely after the start cycle.
- Reset mid-RUN: aborts immediately to the reset values; no done pulse.
- start in the same cycle that done is high: state is IDLE, so start is accepted normally.

Optional Feature:
- Macro: DIV_UNIT_UNSIGNED_EN
- Defined:
  - Adds input port sign_en (1 bit), sampled with start.
  - sign_en=1: signed behaviour as above.
  - sign_en=0: DIVU semantics. Operands are taken raw, with no abs and no FIX negation; sign_q and sign_r are forced to 0.
  - Latency and divide-by-zero handling are identical in both modes.
- Undefined: no sign_en port; always signed.

Test Plan:
- Reset, then A=7, B=2, start for 1 cycle -> busy for 33 cycles, done pulse, lo=0x00000003, hi=0x00000001, div_zero=0.
- A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then A=7, B=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
- Preload hi=1, lo=3; A=5, B=0, start -> next cycle done=1 and div_zero=1, busy never high, hi=1 and lo=3 unchanged.
- A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Start A=100, B=7; pulse start with A=1, B=1 at cycle 10 -> ignored; result lo=14, hi=2 at cycle 34.
- Start A=100, B=7; assert reset at cycle 15 -> hi=lo=0, busy=0 immediately, no done. After release, A=9, B=3 -> lo=3, hi=0.
